// File: rtl/dbus_bridge.sv
// dbus_bridge: one host port steered onto two slave ports by address window.
// Writes are forwarded combinationally and complete in IDLE; one read may be
// outstanding, and its response is routed back with no added latency.
// Optional macro DBUS_BRIDGE_TIMEOUT_EN adds a read-response timeout that
// answers 32'hDEADBEEF with h_error set when the slave stays silent.
module dbus_bridge #(
  parameter logic [31:0] S1_BASE = 32'h8000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_read,
  input  logic        h_write,
  input  logic [31:0] h_address,
  input  logic [31:0] h_writedata,
  input  logic [3:0]  h_byte_enable,
  output logic        h_waitrequest,
  output logic [31:0] h_readdata,
  output logic        h_readdatavalid,
  output logic        h_error,
  output logic        s0_read,
  output logic        s0_write,
  output logic [31:0] s0_address,
  output logic [31:0] s0_writedata,
  output logic [3:0]  s0_byte_enable,
  input  logic        s0_waitrequest,
  input  logic [31:0] s0_readdata,
  input  logic        s0_readdatavalid,
  output logic        s1_read,
  output logic        s1_write,
  output logic [31:0] s1_address,
  output logic [31:0] s1_writedata,
  output logic [3:0]  s1_byte_enable,
  input  logic        s1_waitrequest,
  input  logic [31:0] s1_readdata,
  input  logic        s1_readdatavalid
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("dbus_bridge: TIMEOUT must lie in 1..65535");
  end

  typedef enum logic {IDLE, RESP} state_e;

  state_e      state_q, state_d;
  logic        pend_sel_q, pend_sel_d;
  logic        sel;
  logic        req;
  logic        sel_wait;
  logic        rsp_vld;
  logic [31:0] rsp_data;
  logic        timeout_hit;

  // Address decode and slave-side selection helpers.
  assign sel      = ((h_address & S1_MASK) == S1_BASE);
  assign req      = h_read | h_write;
  assign sel_wait = sel ? s1_waitrequest : s0_waitrequest;
  assign rsp_vld  = pend_sel_q ? s1_readdatavalid : s0_readdatavalid;
  assign rsp_data = pend_sel_q ? s1_readdata : s0_readdata;

  // Address, data and byte enables are broadcast; only strobes are steered.
  assign s0_address     = h_address;
  assign s0_writedata   = h_writedata;
  assign s0_byte_enable = h_byte_enable;
  assign s1_address     = h_address;
  assign s1_writedata   = h_writedata;
  assign s1_byte_enable = h_byte_enable;

`ifdef DBUS_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] tcnt_q, tcnt_d;

  // Counter holds 0 in IDLE so the first RESP cycle sees 0; the count including
  // the current cycle reaches TIMEOUT when tcnt_q equals TIMEOUT-1.
  assign timeout_hit = (state_q == RESP) && !rsp_vld && (tcnt_q == TO_LAST);

  // Next count: clear outside RESP, advance every RESP cycle.
  always_comb begin
    tcnt_d = 16'd0;
    if (state_q == RESP) tcnt_d = tcnt_q + 16'd1;
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tcnt_q <= 16'd0;
    else     tcnt_q <= tcnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and output decode; a simultaneous read+write is a read.
  always_comb begin
    state_d         = state_q;
    pend_sel_d      = pend_sel_q;
    s0_read         = 1'b0;
    s0_write        = 1'b0;
    s1_read         = 1'b0;
    s1_write        = 1'b0;
    h_waitrequest   = 1'b0;
    h_readdatavalid = 1'b0;
    h_readdata      = 32'h0;
    h_error         = 1'b0;
    case (state_q)
      IDLE: begin
        s0_read       = h_read & ~sel;
        s1_read       = h_read & sel;
        s0_write      = h_write & ~h_read & ~sel;
        s1_write      = h_write & ~h_read & sel;
        h_waitrequest = req & sel_wait;
        if (h_read && !sel_wait) begin
          state_d    = RESP;
          pend_sel_d = sel;
        end
      end
      RESP: begin
        h_waitrequest = req;
        if (rsp_vld) begin
          h_readdatavalid = 1'b1;
          h_readdata      = rsp_data;
          state_d         = IDLE;
        end else if (timeout_hit) begin
          h_readdatavalid = 1'b1;
          h_readdata      = 32'hDEAD_BEEF;
          h_error         = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A response seen while reset is applied belongs to a dropped read.
    if (rst) begin
      h_readdatavalid = 1'b0;
      h_readdata      = 32'h0;
      h_error         = 1'b0;
    end
  end

  // FSM state and pending-slave register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_sel_q <= pend_sel_d;
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge. Build with DBUS_BRIDGE_TIMEOUT_EN to include the
// timeout scenarios (DUT instantiated with TIMEOUT=4).
module tb_dbus_bridge;

  logic        clk, rst;
  logic        h_read, h_write;
  logic [31:0] h_address, h_writedata;
  logic [3:0]  h_byte_enable;
  logic        h_waitrequest, h_readdatavalid, h_error;
  logic [31:0] h_readdata;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_address, s0_writedata, s1_address, s1_writedata;
  logic [3:0]  s0_byte_enable, s1_byte_enable;
  logic        s0_waitrequest, s0_readdatavalid, s1_waitrequest, s1_readdatavalid;
  logic [31:0] s0_readdata, s1_readdata;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  dbus_bridge #(
    .S1_BASE(32'h8000_0000),
    .S1_MASK(32'hF000_0000),
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .h_read(h_read), .h_write(h_write), .h_address(h_address),
    .h_writedata(h_writedata), .h_byte_enable(h_byte_enable),
    .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
    .h_readdatavalid(h_readdatavalid), .h_error(h_error),
    .s0_read(s0_read), .s0_write(s0_write), .s0_address(s0_address),
    .s0_writedata(s0_writedata), .s0_byte_enable(s0_byte_enable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
    .s1_writedata(s1_writedata), .s1_byte_enable(s1_byte_enable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response monitor: every h_readdatavalid pulse must match the scoreboard head.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    checks++;
    if (h_readdatavalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rdv: got data=%h err=%b, required no response", h_readdata, h_error);
      end else begin
        e = sb_q.pop_front();
        if (h_readdata !== e.data || h_error !== e.err) begin
          errors++;
          $display("FAIL rsp_data: got data=%h err=%b, required data=%h err=%b",
                   h_readdata, h_error, e.data, e.err);
        end
      end
    end else if (h_readdatavalid !== 1'b0 || h_readdata !== 32'h0 || h_error !== 1'b0) begin
      errors++;
      $display("FAIL quiet_outputs: got rdv=%b data=%h err=%b, required 0/0/0",
               h_readdatavalid, h_readdata, h_error);
    end
  end

  task automatic idle_inputs();
    h_read = 0; h_write = 0; h_address = 0; h_writedata = 0; h_byte_enable = 0;
    s0_waitrequest = 0; s0_readdata = 0; s0_readdatavalid = 0;
    s1_waitrequest = 0; s1_readdata = 0; s1_readdatavalid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; idle_inputs();
    s0_readdatavalid = 1; s0_readdata = 32'h1111_2222;
    #1;
    checks++;
    if ({h_readdatavalid, h_error, s0_read, s0_write, s1_read, s1_write, h_waitrequest} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {h_readdatavalid, h_error, s0_read, s0_write, s1_read, s1_write, h_waitrequest});
    end
    @(negedge clk);
    rst = 0; s0_readdatavalid = 0;
    #1;
    checks++;
    if ({h_readdatavalid, h_error, s0_read, s1_read, h_waitrequest} !== 5'b0) begin
      errors++;
      $display("FAIL after_reset: got %b, required 00000",
               {h_readdatavalid, h_error, s0_read, s1_read, h_waitrequest});
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    idle_inputs();
    h_write = 1; h_address = 32'h0000_0010; h_writedata = 32'h1234_5678; h_byte_enable = 4'hF;
    #1;
    checks++;
    if ({s0_write, s1_write, s0_read, s1_read, h_waitrequest} !== 5'b10000) begin
      errors++;
      $display("FAIL write_strobes: got s0w/s1w/s0r/s1r/wait=%b, required 10000",
               {s0_write, s1_write, s0_read, s1_read, h_waitrequest});
    end
    checks++;
    if (s0_writedata !== 32'h1234_5678 || s1_writedata !== 32'h1234_5678 ||
        s1_address !== 32'h0000_0010 || s1_byte_enable !== 4'hF) begin
      errors++;
      $display("FAIL write_mirror: got s0wd=%h s1wd=%h s1a=%h s1be=%h, required 12345678/12345678/00000010/f",
               s0_writedata, s1_writedata, s1_address, s1_byte_enable);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    addrs[0] = 32'h8000_0100; addrs[1] = 32'h0000_0200;
    addrs[2] = 32'h8FFF_FFFC; addrs[3] = 32'h9000_0000;
    for (int i = 0; i < 4; i++) begin
      logic exp1;
      exp1 = (addrs[i][31:28] == 4'h8);
      @(negedge clk);
      idle_inputs();
      h_write = 1; h_address = addrs[i]; h_writedata = 32'hA000_0000 + i; h_byte_enable = 4'h3;
      #1;
      checks++;
      if ({s0_write, s1_write, h_waitrequest} !== {~exp1, exp1, 1'b0}) begin
        errors++;
        $display("FAIL b2b_write[%0d]: got s0w/s1w/wait=%b, required %b",
                 i, {s0_write, s1_write, h_waitrequest}, {~exp1, exp1, 1'b0});
      end
    end
  endtask

  task automatic test_read_wait();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      h_read = 1; h_address = 32'h8000_0004; h_byte_enable = 4'hF;
      s1_waitrequest = (c < 2);
      if (c == 2) sb_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
      #1;
      checks++;
      if ({s1_read, s0_read, h_waitrequest} !== {2'b10, (c < 2)}) begin
        errors++;
        $display("FAIL read_wait[%0d]: got s1r/s0r/wait=%b, required %b",
                 c, {s1_read, s0_read, h_waitrequest}, {2'b10, (c < 2)});
      end
    end
    repeat (2) begin
      @(negedge clk);
      idle_inputs();
    end
    @(negedge clk);
    s1_readdatavalid = 1; s1_readdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (h_readdatavalid !== 1'b1 || h_readdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL read_rsp: got rdv=%b data=%h, required 1 cafef00d", h_readdatavalid, h_readdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_resp_stall();
    @(negedge clk);
    idle_inputs();
    h_read = 1; h_address = 32'h0000_0020;
    sb_q.push_back('{data: 32'h1111_2222, err: 1'b0});
    @(negedge clk);
    idle_inputs();
    h_write = 1; h_address = 32'h0000_0030; h_writedata = 32'h7777_8888;
    s1_readdatavalid = 1; s1_readdata = 32'h0000_0099;
    #1;
    checks++;
    if ({h_waitrequest, s0_write, s1_write, s0_read, s1_read, h_readdatavalid} !== 6'b100000) begin
      errors++;
      $display("FAIL stall_ignore_s1: got wait/s0w/s1w/s0r/s1r/rdv=%b, required 100000",
               {h_waitrequest, s0_write, s1_write, s0_read, s1_read, h_readdatavalid});
    end
    @(negedge clk);
    s1_readdatavalid = 0;
    s0_readdatavalid = 1; s0_readdata = 32'h1111_2222;
    #1;
    checks++;
    if ({h_waitrequest, s0_write, h_readdatavalid} !== 3'b101 || h_readdata !== 32'h1111_2222) begin
      errors++;
      $display("FAIL stall_s0_rsp: got wait/s0w/rdv=%b data=%h, required 101 11112222",
               {h_waitrequest, s0_write, h_readdatavalid}, h_readdata);
    end
    @(negedge clk);
    s0_readdatavalid = 0;
    #1;
    checks++;
    if ({h_waitrequest, s0_write, s1_write} !== 3'b010) begin
      errors++;
      $display("FAIL stall_write_accept: got wait/s0w/s1w=%b, required 010",
               {h_waitrequest, s0_write, s1_write});
    end
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    idle_inputs();
    h_read = 1; h_write = 1; h_address = 32'h0000_0040;
    sb_q.push_back('{data: 32'h0BAD_CAFE, err: 1'b0});
    #1;
    checks++;
    if ({s0_read, s0_write, s1_read, s1_write} !== 4'b1000) begin
      errors++;
      $display("FAIL rw_both: got s0r/s0w/s1r/s1w=%b, required 1000",
               {s0_read, s0_write, s1_read, s1_write});
    end
    @(negedge clk);
    idle_inputs();
    s0_readdatavalid = 1; s0_readdata = 32'h0BAD_CAFE;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_rdv_idle();
    @(negedge clk);
    idle_inputs();
    s0_readdatavalid = 1; s0_readdata = 32'h1234_0000;
    s1_readdatavalid = 1; s1_readdata = 32'h0000_4321;
    #1;
    checks++;
    if (h_readdatavalid !== 1'b0 || h_readdata !== 32'h0) begin
      errors++;
      $display("FAIL rdv_in_idle: got rdv=%b data=%h, required 0 00000000", h_readdatavalid, h_readdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_resp();
    @(negedge clk);
    idle_inputs();
    h_read = 1; h_address = 32'h0000_0050;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    s0_readdatavalid = 1; s0_readdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (h_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL late_rdv_after_reset: got rdv=%b, required 0", h_readdatavalid);
    end
    @(negedge clk);
    idle_inputs();
    h_read = 1; h_address = 32'h0000_0060;
    sb_q.push_back('{data: 32'h55AA_55AA, err: 1'b0});
    @(negedge clk);
    idle_inputs();
    s0_readdatavalid = 1; s0_readdata = 32'h55AA_55AA;
    #1;
    checks++;
    if (h_readdatavalid !== 1'b1 || h_readdata !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL read_after_reset: got rdv=%b data=%h, required 1 55aa55aa", h_readdatavalid, h_readdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

`ifdef DBUS_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    idle_inputs();
    h_read = 1; h_address = 32'h0000_0070;
    sb_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if ({h_readdatavalid, h_error} !== {(c == 4), (c == 4)}) begin
        errors++;
        $display("FAIL timeout_cycle[%0d]: got rdv/err=%b, required %b",
                 c, {h_readdatavalid, h_error}, {(c == 4), (c == 4)});
      end
    end
    @(negedge clk);
    h_write = 1; h_address = 32'h0000_0074;
    #1;
    checks++;
    if ({s0_write, h_waitrequest} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_back_idle: got s0w/wait=%b, required 10", {s0_write, h_waitrequest});
    end
    @(negedge clk);
    idle_inputs();
    h_read = 1; h_address = 32'h8000_0078;
    sb_q.push_back('{data: 32'h0600_D000, err: 1'b0});
    repeat (3) begin
      @(negedge clk);
      idle_inputs();
    end
    @(negedge clk);
    s1_readdatavalid = 1; s1_readdata = 32'h0600_D000;
    #1;
    checks++;
    if ({h_readdatavalid, h_error} !== 2'b10 || h_readdata !== 32'h0600_D000) begin
      errors++;
      $display("FAIL timeout_race: got rdv/err=%b data=%h, required 10 0600d000",
               {h_readdatavalid, h_error}, h_readdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_write();
    test_back_to_back();
    test_read_wait();
    test_resp_stall();
    test_rw_both();
    test_rdv_idle();
    test_reset_mid_resp();
`ifdef DBUS_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending responses, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
